// File: rtl/mon_arb_pkg.sv
// mon_arb_pkg: FSM state encoding and default widths shared by the mon_arb slice
package mon_arb_pkg;
   typedef enum logic [1:0] {RR = 2'd0, LOCK_WAIT = 2'd1, LOCK = 2'd2} state_t;
   localparam int AW_DEF = 16;
   localparam int DW_DEF = 32;
endpackage

// File: rtl/mon_arb_rr_pick2.sv
// rr_pick2: two-way round-robin picker
//   req_a/req_b in, last_b = requester b was served last, gnt_a/gnt_b one-hot out
module rr_pick2 (
   input  logic req_a,
   input  logic req_b,
   input  logic last_b,
   output logic gnt_a,
   output logic gnt_b
);
   assign gnt_a = req_a & (~req_b | last_b);
   assign gnt_b = req_b & ~gnt_a;
endmodule

// File: rtl/mon_arb.sv
// mon_arb: arbitrates a single-port memory between the CPU and the UART monitor, with monitor lock
//   cpu_*/mon_*: request, grant and one-cycle-later read return per requester
//   mon_lock/locked: monitor exclusive ownership request and status
//   mem_*: shared memory port; resetn is a synchronous active-high reset
module mon_arb
   import mon_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          mon_req,
   input  logic          mon_we,
   input  logic [AW-1:0] mon_addr,
   input  logic [DW-1:0] mon_wdata,
   output logic          mon_gnt,
   output logic          mon_rvalid,
   output logic [DW-1:0] mon_rdata,
   input  logic          mon_lock,
   output logic          locked,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          cpu_stall
);
   state_t state, state_nx;
   logic last_mon, pick_c, pick_m, grab, cpu_rv_q, mon_rv_q;
   logic [DW-1:0] cpu_hold, mon_hold;
   rr_pick2 u_pick (
      .req_a (cpu_req),
      .req_b (mon_req),
      .last_b(last_mon),
      .gnt_a (pick_c),
      .gnt_b (pick_m)
   );
   always_ff @(posedge clk) state <= resetn ? RR : state_nx;
   // RR and LOCK_WAIT share their exits; they differ only in being a lock request in flight
   always_comb state_nx = (state == LOCK) ? (mon_lock ? LOCK : RR)
                                          : (mon_lock ? (mon_req ? LOCK : LOCK_WAIT) : RR);
   // grab: a locking monitor request overrides the round-robin choice as the lock is taken
   always_comb begin
      grab    = mon_lock & mon_req;
      cpu_gnt = ~resetn & (state != LOCK) & ~grab & pick_c;
      mon_gnt = ~resetn & ((state == LOCK) ? mon_req : (grab | pick_m));
      locked  = ~resetn & (state == LOCK);
   end
   always_ff @(posedge clk) begin
      if (resetn) begin
         last_mon <= 1'b1;
         cpu_rv_q <= 1'b0;
         mon_rv_q <= 1'b0;
         cpu_hold <= '0;
         mon_hold <= '0;
      end else begin
         last_mon <= (cpu_gnt | mon_gnt) ? mon_gnt : last_mon;
         cpu_rv_q <= cpu_gnt & ~cpu_we;
         mon_rv_q <= mon_gnt & ~mon_we;
         cpu_hold <= cpu_rv_q ? mem_rdata : cpu_hold;
         mon_hold <= mon_rv_q ? mem_rdata : mon_hold;
      end
   end
   // read data passes straight through in the return cycle, then the captured copy holds
   assign cpu_rvalid = cpu_rv_q & ~resetn;
   assign mon_rvalid = mon_rv_q & ~resetn;
   assign cpu_rdata  = resetn ? '0 : (cpu_rv_q ? mem_rdata : cpu_hold);
   assign mon_rdata  = resetn ? '0 : (mon_rv_q ? mem_rdata : mon_hold);
   assign mem_en     = cpu_gnt | mon_gnt;
   assign mem_we     = mon_gnt ? mon_we : (cpu_gnt & cpu_we);
   assign mem_addr   = mon_gnt ? mon_addr : cpu_addr;
   assign mem_wdata  = mon_gnt ? mon_wdata : cpu_wdata;
   assign cpu_stall  = cpu_req & ~cpu_gnt;
endmodule

// File: doc/mon_arb.md
MON_ARB -- requirements
Module: mon_arb

Interface
REQ-001 The block SHALL have parameter AW, default 16, giving the word-address width of the shared memory.
REQ-002 The block SHALL have parameter DW, default 32, giving the data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: synchronous reset, active-high despite the name; it is sampled only on the rising edge of clk.
REQ-005 The block SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, AW) and cpu_wdata (input, DW): the CPU access request.
REQ-006 The block SHALL have ports cpu_gnt (output, 1), cpu_rvalid (output, 1) and cpu_rdata (output, DW): the CPU grant and read return.
REQ-007 The block SHALL have ports mon_req (input, 1), mon_we (input, 1), mon_addr (input, AW) and mon_wdata (input, DW): the UART monitor access request.
REQ-008 The block SHALL have ports mon_gnt (output, 1), mon_rvalid (output, 1) and mon_rdata (output, DW): the monitor grant and read return.
REQ-009 The block SHALL have port mon_lock, input, 1 bit: the monitor requests exclusive ownership of memory.
REQ-010 The block SHALL have port locked, output, 1 bit: high while exclusive ownership is held.
REQ-011 The block SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, AW) and mem_wdata (output, DW): the single-port memory request.
REQ-012 The block SHALL have port mem_rdata, input, DW: memory read data, valid one cycle after mem_en=1 with mem_we=0.
REQ-013 The block SHALL have port cpu_stall, output, 1 bit: equal to cpu_req & ~cpu_gnt.

Function
REQ-014 At most one grant SHALL be high per cycle; a grant is combinational in the request cycle and the granted request drives mem_* in that same cycle.
REQ-015 In state RR, if exactly one of cpu_req/mon_req is high, that requester SHALL be granted.
REQ-016 In state RR, if both requests are high, the requester not served last (last_mon flag) SHALL be granted; after reset last_mon=1, so the CPU wins the first tie.
REQ-017 last_mon SHALL update only on a grant: set to 1 on mon_gnt and to 0 on cpu_gnt.
REQ-018 FSM states SHALL be RR, LOCK_WAIT and LOCK.
REQ-019 RR SHALL go to LOCK on mon_lock & mon_req; the monitor is granted that cycle regardless of cpu_req.
REQ-020 RR SHALL go to LOCK_WAIT on mon_lock & ~mon_req; CPU grants continue normally in LOCK_WAIT.
REQ-021 LOCK_WAIT SHALL go to LOCK on the first mon_req, granting the monitor that cycle.
REQ-022 LOCK_WAIT SHALL return to RR if mon_lock drops.
REQ-023 In LOCK, cpu_gnt=0, mon_gnt=mon_req and locked=1; LOCK SHALL return to RR in the cycle after mon_lock is sampled low.
REQ-024 A granted read SHALL raise the requester's rvalid exactly one cycle later, with rdata=mem_rdata; the other requester's rvalid stays 0.
REQ-025 A granted write SHALL produce no rvalid.
REQ-026 rdata outputs SHALL hold their last value when rvalid=0.
REQ-027 When there is no grant: mem_en=0, mem_we=0, and mem_addr/mem_wdata are don't-care.
REQ-028 Back-to-back grants, including alternating requesters with pipelined rvalid, SHALL sustain one access per cycle.

Reset
REQ-029 While resetn=1, state SHALL be RR, last_mon=1, and locked, cpu_rvalid, mon_rvalid and mem_en SHALL all be 0.
REQ-030 While resetn=1, both grants SHALL be 0 and cpu_rdata/mon_rdata SHALL be 0.
REQ-031 Reset asserted mid-lock or with a read outstanding SHALL drop the lock and suppress the pending rvalid.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (RR=2'd0, LOCK_WAIT=2'd1, LOCK=2'd2) and the default AW/DW constants.
REQ-033 The two-way round-robin picker SHALL be a sub-module named rr_pick2.
REQ-034 The top-level cpu SHALL instantiate mon_arb between the core and the instruction/data RAM.

Verification
REQ-035 Scenario: reset, then both requesters read simultaneously for 4 cycles -> grants go CPU, MON, CPU, MON, with each rvalid one cycle after its grant.
REQ-036 Scenario: CPU writes 0xDEADBEEF to 0x0010, then the monitor reads 0x0010 -> mon_rvalid=1 with mon_rdata=0xDEADBEEF; cpu_rvalid stays 0.
REQ-037 Scenario: mon_lock=1 with mon_req=0 while the CPU streams reads -> CPU keeps its grants; the first mon_req enters LOCK, after which cpu_stall=1 and locked=1.
REQ-038 Scenario: in LOCK, the monitor performs 3 writes, then deasserts mon_lock -> next cycle locked=0 and the pending CPU request is granted.
REQ-039 Scenario: resetn pulsed high in the cycle after a granted read -> no rvalid asserts, locked=0, and the next tie is granted to the CPU.
